seg7_scan_display: RTL and testbench
====================================

Name: seg7_scan_display

Overview:
- Parametrised multiplexed 7-segment display driver for N common-anode digits.
- Accepts either a binary value, converted to decimal by an iterative double-dabble unit, or raw per-digit segment patterns for text such as menu words.
- Adds leading-zero blanking, over-range indication, per-digit blinking and anti-ghosting blanking between digits.
- Sits between a control FSM (e.g. vending/process controller) and the board's segment/enable pins.

Parameters:
- DIGITS, 4, number of digit positions (2..8).
- VALUE_W, 14, width of binary input value.
- REFRESH_DIV, 250000, clk cycles per digit scan slot.
- BLINK_DIV, 16666667, clk cycles per blink half-period.
- LZB, 1, 1 = enable leading-zero blanking.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- value_in  in  VALUE_W  binary value to display.
- load  in  1  one-cycle strobe: start conversion of value_in.
- raw_in  in  8*DIGITS  raw patterns; byte k drives digit k.
- raw_load  in  1  one-cycle strobe: latch raw_in directly to display.
- blink_mask  in  DIGITS  bit k = 1: digit k blinks.
- busy  out  1  conversion in progress.
- seg  out  8  segments, active-low: seg[6:0] = {a,b,c,d,e,f,g}, seg[7] = dp.
- en  out  DIGITS  digit enables, active-low; en[0] = units (rightmost).

Behaviour:
- Reset (asynchronous):
  - en = all 1, seg = 8'hFF, busy = 0.
  - Display register = all blank (8'hFF per digit).
  - Scan index = 0; refresh and blink counters = 0; blink phase = on.
- Scan:
  - Refresh counter counts 0..REFRESH_DIV-1.
  - At terminal count, scan index advances k -> k+1, wrapping DIGITS-1 -> 0.
  - During the cycle of the terminal count, en = all 1 (dead-time, anti-ghost).
  - Otherwise en = ~(1<<k) and seg = the display byte for digit k.
  - Outputs are registered.
- Blink:
  - Free-running counter toggles the phase every BLINK_DIV cycles.
  - In the off phase, a digit with its blink_mask bit set outputs seg = 8'hFF; its en is unchanged.
  - blink_mask is sampled live, not latched.
- Conversion FSM, states IDLE -> SHIFT -> COMMIT -> IDLE:
  - load in IDLE: capture value_in; busy = 1 from the next cycle.
  - SHIFT lasts exactly VALUE_W cycles of add-3/shift over 4*DIGITS BCD bits.
  - COMMIT lasts one cycle: font-encode digits and write the display register atomically; busy = 0 the following cycle.
  - Total load-to-display latency = VALUE_W+2 cycles.
  - load while busy: ignored, no queueing.
- Over-range (captured value > 10^DIGITS - 1): COMMIT writes all digits = dash (8'b1111_1110), not a truncated number.
- Leading-zero blanking (LZB=1): digits above the most significant non-zero digit get 8'hFF. Digit 0 is always shown, so value 0 -> "   0". With LZB=0, all digits are shown.
- Decimal points are never lit in numeric mode (seg[7] = 1).
- Raw path:
  - raw_load writes raw_in to the display register on the next edge.
  - If a conversion is in progress it is aborted: FSM -> IDLE, busy = 0 on the next cycle, no COMMIT.
  - raw_load and load in the same cycle: raw wins, load is dropped.
- The display register holds its content until the next COMMIT or raw_load.
- Reset mid-conversion: everything returns to reset values immediately, and the display is blank.

Decomposition:
- Package seg7_pkg holds:
  - constants SEG_BLANK = 8'hFF and SEG_DASH = 8'hFE;
  - font function digit -> pattern, with 0 = 8'h81 and 1 = 8'hCF (dp bit = 1), etc.;
  - FSM state typedef.
- Sub-module bin2bcd_seq (parametrised VALUE_W, DIGITS): iterative double-dabble with start/done and an over-range flag.
- Scan, blink and encode logic stay in the top block.

Test Plan (REFRESH_DIV=4, BLINK_DIV=32, DIGITS=4, VALUE_W=14):
- Reset, then 20 cycles idle -> en cycles 1110, 1101, 1011, 0111, each held 3 cycles with a 1111 dead cycle at every slot boundary; seg = FF throughout.
- load with value_in=1234 -> busy high 15 cycles; 16 cycles after load the digits read 1,2,3,4 (units on en[0]: 8'h99? no, font for 4 = 8'hCC).
- load with value_in=7 -> digits 3..1 = FF, digit 0 = font(7) = 8'h8F; value_in=0 -> digit 0 = 8'h81, others FF.
- load with value_in=10000 -> all four digits = FE; busy timing is unchanged.
- load 1234, then raw_load on cycle 5 with raw_in = {FF,8E,81,8E} -> busy drops the next cycle, the raw patterns are shown, and 1234 never appears. Also raw_load and load in the same cycle -> raw wins, busy stays 0.
- After load 1234, set blink_mask=4'b0001 -> digit 0 shows FF for 32 cycles, then font(4) for 32 cycles, alternating; other digits are unaffected. Assert rst mid-blink -> en=1111 and seg=FF immediately.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants, font table and conversion FSM states for the
// multiplexed 7-segment display driver.
package seg7_pkg;

   localparam logic [7:0] SEG_BLANK = 8'hFF;
   localparam logic [7:0] SEG_DASH  = 8'hFE;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      COMMIT = 2'd2
   } conv_state_t;

   // Active-low {dp,a,b,c,d,e,f,g}; dp is always dark, non-decimal codes blank.
   function automatic logic [7:0] font(input logic [3:0] d);
      case (d)
         4'd0:    font = 8'h81;
         4'd1:    font = 8'hCF;
         4'd2:    font = 8'h92;
         4'd3:    font = 8'h86;
         4'd4:    font = 8'hCC;
         4'd5:    font = 8'hA4;
         4'd6:    font = 8'hA0;
         4'd7:    font = 8'h8F;
         4'd8:    font = 8'h80;
         4'd9:    font = 8'h84;
         default: font = SEG_BLANK;
      endcase
   endfunction

   function automatic logic [63:0] pow10(input int n);
      logic [63:0] r;
      r = 64'd1;
      for (int i = 0; i < n; i++) r = r * 64'd10;
      return r;
   endfunction

endpackage

// File: rtl/seg7_scan_display_bin2bcd_seq.sv
// Iterative double-dabble converter: one add-3/shift step per cycle, a
// one-cycle COMMIT strobe at the end, and an over-range flag.
module bin2bcd_seq
   import seg7_pkg::*;
#(
   parameter int VALUE_W = 14,
   parameter int DIGITS  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  abort,
   input  logic [VALUE_W-1:0]    value,
   output logic                  busy,
   output logic                  done,
   output logic                  over,
   output logic [4*DIGITS-1:0]   bcd
);

   localparam int              CW      = $clog2(VALUE_W + 1);
   localparam logic [CW-1:0]   CNT_END = CW'(VALUE_W - 1);
   localparam logic [63:0]     MAX_VAL = pow10(DIGITS) - 64'd1;

   conv_state_t         state;
   logic [VALUE_W-1:0]  sr;
   logic [CW-1:0]       cnt;
   logic [4*DIGITS-1:0] adj;

   always_comb begin
      adj = bcd;
      for (int i = 0; i < DIGITS; i++)
         if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
   end

   // Abort from the raw path overrides everything, including COMMIT.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         sr    <= '0;
         cnt   <= '0;
         bcd   <= '0;
         over  <= 1'b0;
      end else if (abort) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE: if (start) begin
               sr    <= value;
               bcd   <= '0;
               cnt   <= '0;
               over  <= 64'(value) > MAX_VAL;
               state <= SHIFT;
            end
            SHIFT: begin
               {bcd, sr} <= {adj, sr} << 1;
               cnt       <= cnt + 1'b1;
               if (cnt == CNT_END) state <= COMMIT;
            end
            COMMIT:  state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign busy = (state != IDLE);
   assign done = (state == COMMIT);

endmodule

// File: rtl/seg7_scan_display.sv
// Multiplexed common-anode 7-segment driver: numeric (via double-dabble)
// or raw display content, with blanking, blinking and scan dead-time.
module seg7_scan_display
   import seg7_pkg::*;
#(
   parameter int DIGITS      = 4,
   parameter int VALUE_W     = 14,
   parameter int REFRESH_DIV = 250000,
   parameter int BLINK_DIV   = 16666667,
   parameter int LZB         = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [VALUE_W-1:0]    value_in,
   input  logic                  load,
   input  logic [8*DIGITS-1:0]   raw_in,
   input  logic                  raw_load,
   input  logic [DIGITS-1:0]     blink_mask,
   output logic                  busy,
   output logic [7:0]            seg,
   output logic [DIGITS-1:0]     en
);

   localparam int              RW       = $clog2(REFRESH_DIV + 1);
   localparam int              BW       = $clog2(BLINK_DIV + 1);
   localparam int              IW       = $clog2(DIGITS);
   localparam logic [RW-1:0]   R_LAST   = RW'(REFRESH_DIV - 1);
   localparam logic [BW-1:0]   B_LAST   = BW'(BLINK_DIV - 1);
   localparam logic [IW-1:0]   IDX_LAST = IW'(DIGITS - 1);
   localparam logic [DIGITS-1:0] EN_ONE = {{(DIGITS-1){1'b0}}, 1'b1};

   logic [RW-1:0]            rcnt;
   logic [BW-1:0]            bcnt;
   logic [IW-1:0]            idx;
   logic                     blink_on;
   logic                     scan_tc, blink_tc;
   logic                     done, over, lz_seen;
   logic [4*DIGITS-1:0]      bcd;
   logic [DIGITS-1:0][7:0]   disp, enc;

   bin2bcd_seq #(.VALUE_W(VALUE_W), .DIGITS(DIGITS)) u_conv (
      .clk   (clk),
      .rst   (rst),
      .start (load & ~raw_load),
      .abort (raw_load),
      .value (value_in),
      .busy  (busy),
      .done  (done),
      .over  (over),
      .bcd   (bcd)
   );

   // Scan from the top digit down so blanking stops at the first non-zero digit.
   always_comb begin
      enc     = '1;
      lz_seen = 1'b0;
      for (int k = DIGITS - 1; k >= 0; k--) begin
         if (bcd[4*k +: 4] != 4'd0) lz_seen = 1'b1;
         if (over)                                enc[k] = SEG_DASH;
         else if (LZB != 0 && !lz_seen && k != 0) enc[k] = SEG_BLANK;
         else                                     enc[k] = font(bcd[4*k +: 4]);
      end
   end

   assign scan_tc  = (rcnt == R_LAST);
   assign blink_tc = (bcnt == B_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rcnt     <= '0;
         bcnt     <= '0;
         idx      <= '0;
         blink_on <= 1'b1;
         disp     <= {DIGITS{SEG_BLANK}};
      end else begin
         rcnt <= scan_tc ? '0 : rcnt + 1'b1;
         bcnt <= blink_tc ? '0 : bcnt + 1'b1;
         if (scan_tc)  idx      <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
         if (blink_tc) blink_on <= ~blink_on;
         if (raw_load)  disp <= raw_in;
         else if (done) disp <= enc;
      end
   end

   // Terminal-count cycle is dead time: all digits off while the index moves.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         en  <= '1;
         seg <= SEG_BLANK;
      end else if (scan_tc) begin
         en  <= '1;
         seg <= SEG_BLANK;
      end else begin
         en  <= ~(EN_ONE << idx);
         seg <= (!blink_on && blink_mask[idx]) ? SEG_BLANK : disp[idx];
      end
   end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed bench for seg7_scan_display with a small scan/blink timing model.
module tb_seg7_scan_display;

   localparam int DIGITS  = 4;
   localparam int VALUE_W = 14;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic [VALUE_W-1:0]   value_in = '0;
   logic                 load = 1'b0;
   logic [8*DIGITS-1:0]  raw_in = '0;
   logic                 raw_load = 1'b0;
   logic [DIGITS-1:0]    blink_mask = '0;
   logic                 busy;
   logic [7:0]           seg;
   logic [DIGITS-1:0]    en;

   int nvec = 0;
   int nerr = 0;
   int p    = 0;
   logic [7:0] dm [DIGITS];

   seg7_scan_display #(
      .DIGITS(DIGITS), .VALUE_W(VALUE_W), .REFRESH_DIV(4), .BLINK_DIV(32), .LZB(1)
   ) dut (
      .clk(clk), .rst(rst), .value_in(value_in), .load(load), .raw_in(raw_in),
      .raw_load(raw_load), .blink_mask(blink_mask), .busy(busy), .seg(seg), .en(en)
   );

   always #5 clk = ~clk;

   // Edges since reset release; drives the expected scan slot and blink phase.
   always @(posedge clk or posedge rst)
      if (rst) p <= 0;
      else     p <= p + 1;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %h expected %h (edge %0d)", tag, obs, exp, p);
      end
   endtask

   task automatic chk_scan(input string tag);
      int slot, k;
      logic ph_on;
      logic [3:0] een;
      logic [7:0] es;
      slot  = (p - 1) % 4;
      k     = ((p - 1) / 4) % 4;
      ph_on = (((p - 1) / 32) % 2) == 0;
      if (slot == 3) begin
         een = 4'hF;
         es  = 8'hFF;
      end else begin
         een = ~(4'b0001 << k);
         es  = (blink_mask[k] && !ph_on) ? 8'hFF : dm[k];
      end
      chk({tag, "_en"}, 32'(en), 32'(een));
      chk({tag, "_seg"}, 32'(seg), 32'(es));
   endtask

   task automatic set_dm(input logic [7:0] d3, input logic [7:0] d2,
                         input logic [7:0] d1, input logic [7:0] d0);
      dm[3] = d3; dm[2] = d2; dm[1] = d1; dm[0] = d0;
   endtask

   // Load, check busy for exactly 15 cycles, and leave the new content visible.
   task automatic do_load(input logic [VALUE_W-1:0] v, input string tag);
      value_in = v;
      load     = 1'b1;
      tick();
      load = 1'b0;
      for (int i = 0; i < 15; i++) begin
         chk({tag, "_busy_hi"}, 32'(busy), 32'd1);
         tick();
      end
      chk({tag, "_busy_lo"}, 32'(busy), 32'd0);
      tick();
   endtask

   task automatic scan_run(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         chk_scan(tag);
         tick();
      end
   endtask

   initial begin
      set_dm(8'hFF, 8'hFF, 8'hFF, 8'hFF);
      #12;
      chk("rst_en", 32'(en), 32'hF);
      chk("rst_seg", 32'(seg), 32'hFF);
      chk("rst_busy", 32'(busy), 32'd0);
      tick();
      rst = 1'b0;
      tick();

      scan_run(20, "idle");

      do_load(14'd1234, "v1234");
      set_dm(8'hCF, 8'h92, 8'h86, 8'hCC);
      scan_run(20, "d1234");

      do_load(14'd7, "v7");
      set_dm(8'hFF, 8'hFF, 8'hFF, 8'h8F);
      scan_run(16, "d7");

      do_load(14'd0, "v0");
      set_dm(8'hFF, 8'hFF, 8'hFF, 8'h81);
      scan_run(16, "d0");

      do_load(14'd10000, "vovr");
      set_dm(8'hFE, 8'hFE, 8'hFE, 8'hFE);
      scan_run(16, "dovr");

      do_load(14'd9999, "v9999");
      set_dm(8'h84, 8'h84, 8'h84, 8'h84);
      scan_run(16, "d9999");

      // Abort a conversion in flight with a raw write
      value_in = 14'd1234;
      load     = 1'b1;
      tick();
      load = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      raw_in   = {8'hFF, 8'h8E, 8'h81, 8'h8E};
      raw_load = 1'b1;
      tick();
      raw_load = 1'b0;
      chk("abort_busy", 32'(busy), 32'd0);
      tick();
      set_dm(8'hFF, 8'h8E, 8'h81, 8'h8E);
      for (int i = 0; i < 24; i++) begin
         chk_scan("raw");
         chk("raw_busy", 32'(busy), 32'd0);
         tick();
      end

      // Simultaneous load and raw_load: raw wins
      value_in = 14'd1234;
      raw_in   = {8'h92, 8'h92, 8'h92, 8'hA4};
      load     = 1'b1;
      raw_load = 1'b1;
      tick();
      load     = 1'b0;
      raw_load = 1'b0;
      chk("both_busy", 32'(busy), 32'd0);
      tick();
      set_dm(8'h92, 8'h92, 8'h92, 8'hA4);
      for (int i = 0; i < 16; i++) begin
         chk_scan("both");
         chk("both_busy_hold", 32'(busy), 32'd0);
         tick();
      end

      // Blink on digit 0 across several phases
      do_load(14'd1234, "vblink");
      set_dm(8'hCF, 8'h92, 8'h86, 8'hCC);
      blink_mask = 4'b0001;
      scan_run(80, "blink");

      // Reset in the middle of a conversion, between clock edges
      value_in = 14'd4321;
      load     = 1'b1;
      tick();
      load = 1'b0;
      tick();
      tick();
      #2 rst = 1'b1;
      #1;
      chk("mrst_en", 32'(en), 32'hF);
      chk("mrst_seg", 32'(seg), 32'hFF);
      chk("mrst_busy", 32'(busy), 32'd0);
      tick();
      rst = 1'b0;
      tick();
      set_dm(8'hFF, 8'hFF, 8'hFF, 8'hFF);
      for (int i = 0; i < 24; i++) begin
         chk_scan("post_rst");
         chk("post_rst_busy", 32'(busy), 32'd0);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
